hls_deadlock_axis_monitor: RTL and testbench
============================================

HLS_DEADLOCK_AXIS_MONITOR -- requirements
Module: hls_deadlock_axis_monitor

Interface
REQ-001 SHALL have parameter N_AXIS, default 4, number of monitored AXI-Stream block signals (1..32).
REQ-002 SHALL have parameter N_INST, default 2, number of monitored sub-instances (1..32).
REQ-003 SHALL have parameter THRESH, default 16, consecutive blocked cycles before a channel counts as stalled (1..65535).
REQ-004 SHALL have parameter STICKY, default 1; 1 = deadlock latched until reset/clear, 0 = self-clearing.
REQ-005 SHALL have one clock and a synchronous active-high reset; the reset port is the clock-domain reset.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 clear  input  1  synchronous soft clear, same effect as reset.
REQ-009 axis_block_sigs  input  N_AXIS  bit i high = stream i blocked this cycle.
REQ-010 inst_idle_sigs  input  N_INST  bit j high = instance j idle.
REQ-011 inst_block_sigs  input  N_INST  bit j high = instance j blocked.
REQ-012 axis_block_info  output  N_AXIS  active-high mask of stalled streams, registered.
REQ-013 first_idx  output  5  lowest stalled stream index captured on deadlock entry, registered.
REQ-014 stall_cycles  output  32  cycles spent in DEADLOCK since entry, registered.
REQ-015 block  output  1  deadlock flag, registered.

Function
REQ-016 SHALL keep per-stream counter cnt[i], width clog2(THRESH+1): sig[i]=0 -> 0; sig[i]=1 -> cnt+1, saturating at THRESH.
REQ-017 stalled[i] SHALL be (cnt[i] == THRESH), decoded from the registered counter.
REQ-018 quiet SHALL be true when every bit of (inst_idle_sigs | inst_block_sigs) is 1 (no instance running).
REQ-019 SHALL implement FSM states IDLE, WATCH, DEADLOCK; reset state IDLE.
REQ-020 IDLE -> WATCH when any axis_block_sigs bit is 1; else stay.
REQ-021 WATCH -> DEADLOCK when any stalled[i] and quiet; WATCH -> IDLE when all axis_block_sigs are 0; DEADLOCK transition has priority when both conditions hold.
REQ-022 DEADLOCK with STICKY=1 SHALL hold until reset or clear.
REQ-023 DEADLOCK with STICKY=0 SHALL go to IDLE when no stalled[i] is set or quiet is false.
REQ-024 block SHALL be 1 exactly when state == DEADLOCK; with sig[i] first high in cycle 0 and held, plus quiet held, block SHALL rise in cycle THRESH+1.
REQ-025 On the WATCH->DEADLOCK edge, axis_block_info SHALL load stalled[], and first_idx SHALL load the lowest set index.
REQ-026 In DEADLOCK, axis_block_info SHALL OR in newly stalled bits (STICKY=1) or track stalled[] each cycle (STICKY=0); first_idx SHALL hold.
REQ-027 Outside DEADLOCK, axis_block_info and first_idx SHALL be 0.
REQ-028 stall_cycles SHALL load 1 on entry, increment each DEADLOCK cycle, saturate at 0xFFFFFFFF, and be 0 outside DEADLOCK.
REQ-029 A stream deasserting for one cycle SHALL zero its counter; a stall restarts the THRESH count from 0.
REQ-030 Unused first_idx upper bits SHALL be 0 when N_AXIS < 32.

Reset
REQ-031 reset or clear SHALL zero all cnt[i], force IDLE, and in the same edge set block=0, axis_block_info=0, first_idx=0, stall_cycles=0.
REQ-032 reset/clear SHALL win over any simultaneous transition; the monitor restarts counting the cycle after deassertion.

Verification
REQ-033 N_AXIS=4, THRESH=4, quiet=1, sig[2] held high from cycle 0 -> block=1 at cycle 5, axis_block_info=4'b0100, first_idx=2, stall_cycles=1 at cycle 5 and 2 at cycle 6.
REQ-034 THRESH=4, sig[1] high for cycles 0-2, low in cycle 3, high again from cycle 4 -> no block before cycle 9; block=1 at cycle 9.
REQ-035 THRESH=4, sig[0] held, one inst_idle/inst_block bit pair 0/0 throughout -> block stays 0 and state stays WATCH indefinitely.
REQ-036 STICKY=0 in DEADLOCK, drop sig[2] -> block=0 two cycles later and all info outputs 0; STICKY=1 same stimulus -> block stays 1 and stall_cycles keeps counting.
REQ-037 In DEADLOCK with STICKY=1, assert clear for one cycle while sigs remain high -> all outputs 0 the next cycle; block re-rises THRESH+1 cycles after clear deasserts.
REQ-038 Streams 1 and 3 stall together -> first_idx=1, axis_block_info=4'b1010; long run with stall_cycles forced near max -> saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/hls_deadlock_axis_monitor.sv
// hls_deadlock_axis_monitor: flags a deadlock when AXI-Stream channels stay blocked
// for THRESH cycles while every monitored instance is idle or blocked.
module hls_deadlock_axis_monitor #(
    parameter int N_AXIS = 4,
    parameter int N_INST = 2,
    parameter int THRESH = 16,
    parameter int STICKY = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic [N_AXIS-1:0] i_axis_block_sigs,
    input  logic [N_INST-1:0] i_inst_idle_sigs,
    input  logic [N_INST-1:0] i_inst_block_sigs,
    output logic [N_AXIS-1:0] o_axis_block_info,
    output logic [4:0]        o_first_idx,
    output logic [31:0]       o_stall_cycles,
    output logic              o_block
);
    localparam int CW = $clog2(THRESH + 1);
    typedef enum logic [1:0] {S_IDLE, S_WATCH, S_DL} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt [N_AXIS];
    logic [N_AXIS-1:0] w_stalled, r_info, w_info;
    logic [4:0]        r_first, w_first, w_low;
    logic [31:0]       r_sc, w_sc;
    logic              w_rst, w_quiet, w_any_sig, w_dl_cond;
    assign w_rst     = i_reset | i_clear;
    assign w_quiet   = &(i_inst_idle_sigs | i_inst_block_sigs);
    assign w_any_sig = |i_axis_block_sigs;
    assign w_dl_cond = (|w_stalled) & w_quiet;
    genvar g;
    generate
        for (g = 0; g < N_AXIS; g++) begin : g_cnt
            always_ff @(posedge i_clock) begin
                if (w_rst || !i_axis_block_sigs[g])
                    r_cnt[g] <= '0;
                else if (r_cnt[g] != CW'(THRESH))
                    r_cnt[g] <= r_cnt[g] + 1'b1;
            end
            assign w_stalled[g] = (r_cnt[g] == CW'(THRESH));
        end
    endgenerate
    always_ff @(posedge i_clock) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_info  <= '0;
            r_first <= '0;
            r_sc    <= '0;
        end else begin
            r_state <= w_next;
            r_info  <= w_info;
            r_first <= w_first;
            r_sc    <= w_sc;
        end
    end
    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE:  w_next = w_any_sig ? S_WATCH : S_IDLE;
            S_WATCH: w_next = w_dl_cond ? S_DL : (w_any_sig ? S_WATCH : S_IDLE);
            S_DL:    w_next = (STICKY != 0 || w_dl_cond) ? S_DL : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    // Info registers are computed from the next state so they change on the same edge as o_block.
    always_comb begin
        w_low = '0;
        for (int i = N_AXIS - 1; i >= 0; i--)
            if (w_stalled[i]) w_low = 5'(i);
        w_info  = '0;
        w_first = '0;
        w_sc    = '0;
        if (w_next == S_DL && r_state != S_DL) begin
            w_info  = w_stalled;
            w_first = w_low;
            w_sc    = 32'd1;
        end else if (w_next == S_DL) begin
            w_info  = (STICKY != 0) ? (r_info | w_stalled) : w_stalled;
            w_first = r_first;
            w_sc    = (&r_sc) ? r_sc : r_sc + 32'd1;
        end
    end
    assign o_block           = (r_state == S_DL);
    assign o_axis_block_info = r_info;
    assign o_first_idx       = r_first;
    assign o_stall_cycles    = r_sc;
endmodule

// File: tb/tb_hls_deadlock_axis_monitor.sv
// tb_hls_deadlock_axis_monitor: directed and random checks of both STICKY variants
// against a run-length based reference model.
module tb_hls_deadlock_axis_monitor;
    localparam int TH = 4;
    logic       clk = 0, rst = 1, clear = 0;
    logic [3:0] sig = '0;
    logic [1:0] idle = '0, iblk = '0;
    logic [3:0] info0, info1;
    logic [4:0] first0, first1;
    logic [31:0] sc0, sc1;
    logic       block0, block1;
    int         errs = 0, checks = 0;
    int         run [4];
    int         m_st [2];
    logic [3:0] m_info [2];
    logic [4:0] m_first [2];
    logic [31:0] m_sc [2];

    always #5 clk = ~clk;

    hls_deadlock_axis_monitor #(.N_AXIS(4), .N_INST(2), .THRESH(TH), .STICKY(0)) u_s0 (
        .i_clock(clk), .i_reset(rst), .i_clear(clear), .i_axis_block_sigs(sig),
        .i_inst_idle_sigs(idle), .i_inst_block_sigs(iblk), .o_axis_block_info(info0),
        .o_first_idx(first0), .o_stall_cycles(sc0), .o_block(block0));
    hls_deadlock_axis_monitor #(.N_AXIS(4), .N_INST(2), .THRESH(TH), .STICKY(1)) u_s1 (
        .i_clock(clk), .i_reset(rst), .i_clear(clear), .i_axis_block_sigs(sig),
        .i_inst_idle_sigs(idle), .i_inst_block_sigs(iblk), .o_axis_block_info(info1),
        .o_first_idx(first1), .o_stall_cycles(sc1), .o_block(block1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A stream is stalled once it has been blocked for at least TH preceding cycles.
    function automatic void model_update();
        logic [3:0] stl;
        bit q;
        int low;
        for (int i = 0; i < 4; i++) stl[i] = (run[i] >= TH);
        q = &(idle | iblk);
        low = 0;
        for (int i = 3; i >= 0; i--) if (stl[i]) low = i;
        for (int d = 0; d < 2; d++) begin
            int nxt;
            if (rst || clear) begin
                m_st[d] = 0; m_info[d] = '0; m_first[d] = '0; m_sc[d] = '0;
                continue;
            end
            if (m_st[d] == 0) nxt = (sig != 0) ? 1 : 0;
            else if (m_st[d] == 1) nxt = (stl != 0 && q) ? 2 : ((sig != 0) ? 1 : 0);
            else nxt = (d == 1 || (stl != 0 && q)) ? 2 : 0;
            if (nxt == 2 && m_st[d] != 2) begin
                m_info[d] = stl; m_first[d] = 5'(low); m_sc[d] = 1;
            end else if (nxt == 2) begin
                m_info[d] = (d == 1) ? (m_info[d] | stl) : stl;
                if (m_sc[d] != 32'hFFFF_FFFF) m_sc[d] = m_sc[d] + 1;
            end else begin
                m_info[d] = '0; m_first[d] = '0; m_sc[d] = '0;
            end
            m_st[d] = nxt;
        end
        for (int i = 0; i < 4; i++)
            run[i] = (rst || clear || !sig[i]) ? 0 : ((run[i] < 1000) ? run[i] + 1 : run[i]);
    endfunction

    task automatic step(input logic [3:0] s, input logic [1:0] idl, input logic [1:0] blk,
                        input logic clr);
        sig = s; idle = idl; iblk = blk; clear = clr;
        @(posedge clk);
        model_update();
        #1;
        chk("s0_block", 32'(block0), 32'(m_st[0] == 2));
        chk("s0_info", 32'(info0), 32'(m_info[0]));
        chk("s0_first", 32'(first0), 32'(m_first[0]));
        chk("s0_stall", sc0, m_sc[0]);
        chk("s1_block", 32'(block1), 32'(m_st[1] == 2));
        chk("s1_info", 32'(info1), 32'(m_info[1]));
        chk("s1_first", 32'(first1), 32'(m_first[1]));
        chk("s1_stall", sc1, m_sc[1]);
    endtask

    initial begin
        logic [3:0] rs;
        logic [1:0] ri, rb;
        for (int i = 0; i < 4; i++) run[i] = 0;
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_info[d] = '0; m_first[d] = '0; m_sc[d] = '0;
        end
        rst = 1;
        step(4'b1111, 2'b11, 2'b00, 0);
        step(4'b1111, 2'b11, 2'b00, 0);
        chk("reset_block", 32'(block1), 0);
        rst = 0;
        // single stream stall: block rises in cycle TH+1
        for (int k = 0; k < 7; k++) begin
            step(4'b0100, 2'b11, 2'b00, 0);
            if (k == 3) chk("pre_block", 32'(block1), 0);
            if (k == 4) begin
                chk("rise_block", 32'(block1), 1);
                chk("rise_info", 32'(info1), 32'h4);
                chk("rise_first", 32'(first1), 2);
                chk("rise_stall1", sc1, 1);
            end
            if (k == 5) chk("rise_stall2", sc1, 2);
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 2'b11, 2'b00, 0);
            if (k == 1) begin
                chk("drop_s0_block", 32'(block0), 0);
                chk("drop_s1_block", 32'(block1), 1);
            end
        end
        // clear in sticky deadlock, then re-rise
        step(4'b0100, 2'b11, 2'b00, 0);
        step(4'b0100, 2'b11, 2'b00, 1);
        chk("clear_block", 32'(block1), 0);
        chk("clear_stall", sc1, 0);
        for (int k = 0; k < 6; k++) begin
            step(4'b0100, 2'b11, 2'b00, 0);
            if (k == 3) chk("reclr_pre", 32'(block1), 0);
            if (k == 4) chk("reclr_rise", 32'(block1), 1);
        end
        // one-cycle gap restarts the count
        step(4'b0000, 2'b11, 2'b00, 1);
        for (int k = 0; k < 11; k++) begin
            step((k == 3) ? 4'b0000 : 4'b0010, 2'b11, 2'b10, 0);
            if (k == 7) chk("gap_pre", 32'(block1), 0);
            if (k == 8) chk("gap_rise", 32'(block1), 1);
        end
        // a running instance prevents deadlock
        step(4'b0000, 2'b11, 2'b00, 1);
        for (int k = 0; k < 20; k++) step(4'b0001, 2'b01, 2'b00, 0);
        chk("busy_block", 32'(block1), 0);
        // two streams stall together, then saturate stall_cycles
        step(4'b0000, 2'b11, 2'b00, 1);
        for (int k = 0; k < 6; k++) step(4'b1010, 2'b00, 2'b11, 0);
        chk("pair_first", 32'(first1), 1);
        chk("pair_info", 32'(info1), 32'hA);
        force u_s1.r_sc = 32'hFFFF_FFFD;
        #1 release u_s1.r_sc;
        m_sc[1] = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) step(4'b1010, 2'b00, 2'b11, 0);
        chk("sat_stall", sc1, 32'hFFFF_FFFF);
        // random phase
        rs = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) rs = 4'($urandom);
            ri = ($urandom_range(7) != 0) ? 2'b11 : 2'($urandom);
            rb = 2'($urandom);
            step(rs, ri, rb, $urandom_range(49) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
